// File: rtl/pipe_delay_line.sv
// pipe_delay_line: DEPTH-stage register chain carrying a data word and a valid tag.
// Every enabled cycle shifts the chain by one stage. Flush inserts bubbles in every
// stage. occupancy counts the valid stages.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - synchronous active-high reset (priority over flush and en)
//   en         - advance enable; 0 holds every stage
//   flush      - synchronous clear of all stages (priority over en)
//   in_data    - data entering stage 0
//   in_valid   - valid tag for in_data
//   out_data   - data of stage DEPTH-1, driven straight from the register
//   out_valid  - valid tag of stage DEPTH-1, driven straight from the register
//   occupancy  - number of valid stages, 0..DEPTH
module pipe_delay_line #(
   parameter int unsigned       WIDTH       = 32,
   parameter int unsigned       DEPTH       = 3,
   parameter logic [WIDTH-1:0]  FLUSH_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int unsigned OccW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [OccW-1:0]             occ_q, occ_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      occ_d   = occ_q;
      if (flush) begin
         data_d  = {DEPTH{FLUSH_VALUE}};
         valid_d = '0;
         occ_d   = '0;
      end else if (en) begin
         // Data moves regardless of its valid tag; bubbles keep their data bits.
         data_d[0]  = in_data;
         valid_d[0] = in_valid;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         // One word in, one word out per shift: count stays equal to popcount(valid).
         occ_d = occ_q + OccW'(in_valid) - OccW'(valid_q[DEPTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= {DEPTH{FLUSH_VALUE}};
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   assign out_data  = data_q[DEPTH-1];
   assign out_valid = valid_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_delay_line.sv
module tb_pipe_delay_line;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 3;
   localparam logic [7:0]  FV = 8'h5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DEPTH=3 instance
   logic       reset, en, flush, in_valid, out_valid;
   logic [7:0] in_data, out_data;
   logic [1:0] occupancy;

   // DEPTH=1 instance
   logic       reset1, en1, flush1, in_valid1, out_valid1;
   logic [7:0] in_data1, out_data1;
   logic       occupancy1;

   pipe_delay_line #(.WIDTH(W), .DEPTH(D), .FLUSH_VALUE(FV)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .occupancy (occupancy)
   );

   pipe_delay_line #(.WIDTH(W), .DEPTH(1), .FLUSH_VALUE(8'h00)) u_dut1 (
      .clk       (clk),
      .reset     (reset1),
      .en        (en1),
      .flush     (flush1),
      .in_data   (in_data1),
      .in_valid  (in_valid1),
      .out_data  (out_data1),
      .out_valid (out_valid1),
      .occupancy (occupancy1)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       rst, fl, en, v;
      logic [7:0] d;
      logic [7:0] ed;
      logic       ev;
      logic [1:0] eo;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       v;
   } word_t;

   vec_t  vecs[$];
   word_t sb[$];

   function automatic vec_t mk(logic r, logic f, logic e, logic v, logic [7:0] d,
                               logic [7:0] ed, logic ev, logic [1:0] eo);
      vec_t t;
      t.rst = r; t.fl = f; t.en = e; t.v = v; t.d = d;
      t.ed = ed; t.ev = ev; t.eo = eo;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   // Reference: queue of DEPTH words, front = last stage.
   task automatic sb_step(input logic r, input logic f, input logic e, input logic v,
                          input logic [7:0] d);
      word_t w;
      if (r || f) begin
         sb.delete();
         for (int i = 0; i < int'(D); i++) begin
            w.d = FV; w.v = 1'b0;
            sb.push_back(w);
         end
      end else if (e) begin
         w.d = d; w.v = v;
         sb.push_back(w);
         w = sb.pop_front();
      end
   endtask

   function automatic int sb_occ();
      int n = 0;
      foreach (sb[i]) if (sb[i].v) n++;
      return n;
   endfunction

   task automatic drive(input logic r, input logic f, input logic e, input logic v,
                        input logic [7:0] d);
      reset = r; flush = f; en = e; in_valid = v; in_data = d;
      sb_step(r, f, e, v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic r, input logic f, input logic e, input logic v,
                         input logic [7:0] d);
      reset1 = r; flush1 = f; en1 = e; in_valid1 = v; in_data1 = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0;
      reset1 = 1'b1; flush1 = 1'b0; en1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0;

      //                rst fl  en  v   d      exp_d  ev  occ
      vecs.push_back(mk(1, 0, 0, 0, 8'h00, FV,    0, 0)); // reset
      vecs.push_back(mk(0, 0, 1, 1, 8'h11, FV,    0, 1)); // basic latency
      vecs.push_back(mk(0, 0, 1, 1, 8'h22, FV,    0, 2));
      vecs.push_back(mk(0, 0, 1, 1, 8'h33, 8'h11, 1, 3));
      vecs.push_back(mk(0, 0, 1, 1, 8'h44, 8'h22, 1, 3)); // in+out: occ holds
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h33, 1, 2));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h44, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 8'hA1, 8'h00, 0, 1)); // stall
      vecs.push_back(mk(0, 0, 1, 1, 8'hA2, 8'h00, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 8'hFF, 8'h00, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 8'hFF, 8'h00, 0, 2));
      vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 0, 2));
      vecs.push_back(mk(0, 0, 1, 0, 8'h77, 8'hA1, 1, 2));
      vecs.push_back(mk(0, 0, 1, 0, 8'h77, 8'hA2, 1, 1));
      vecs.push_back(mk(0, 0, 0, 1, 8'h99, 8'hA2, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 8'h66, 8'h77, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 8'hB1, 8'h77, 0, 1)); // flush priority
      vecs.push_back(mk(0, 0, 1, 1, 8'hB2, 8'h66, 0, 2));
      vecs.push_back(mk(0, 0, 1, 1, 8'hB3, 8'hB1, 1, 3));
      vecs.push_back(mk(0, 1, 1, 1, 8'h55, FV,    0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, FV,    0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, FV,    0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0)); // 0x55 never shows
      vecs.push_back(mk(0, 0, 1, 1, 8'h01, 8'h00, 0, 1)); // bubbles
      vecs.push_back(mk(0, 0, 1, 0, 8'h02, 8'h00, 0, 1));
      vecs.push_back(mk(0, 0, 1, 1, 8'h03, 8'h01, 1, 2));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h02, 0, 1));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h03, 1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 8'hC1, 8'h00, 0, 1)); // reset priority
      vecs.push_back(mk(0, 0, 1, 1, 8'hC2, 8'h00, 0, 2));
      vecs.push_back(mk(0, 0, 1, 1, 8'hC3, 8'hC1, 1, 3));
      vecs.push_back(mk(1, 1, 1, 1, 8'hDD, FV,    0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 8'hE1, FV,    0, 1)); // first word after reset
      vecs.push_back(mk(0, 0, 1, 1, 8'hE2, FV,    0, 2));
      vecs.push_back(mk(0, 0, 1, 1, 8'hE3, 8'hE1, 1, 3));
      vecs.push_back(mk(0, 1, 0, 0, 8'h00, FV,    0, 0)); // flush while disabled

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].fl, vecs[i].en, vecs[i].v, vecs[i].d);
         chk("tbl_data",  i, 32'(out_data),  32'(vecs[i].ed));
         chk("tbl_valid", i, 32'(out_valid), 32'(vecs[i].ev));
         chk("tbl_occ",   i, 32'(occupancy), 32'(vecs[i].eo));
      end

      // DEPTH=1 corner sequence
      drive1(1, 0, 0, 0, 8'h00);
      chk("d1_rst_data", 0, 32'(out_data1), 32'h00);
      chk("d1_rst_occ",  0, 32'(occupancy1), 32'h0);
      drive1(0, 0, 1, 1, 8'hFF);
      chk("d1_data",  1, 32'(out_data1),  32'hFF);
      chk("d1_valid", 1, 32'(out_valid1), 32'h1);
      chk("d1_occ",   1, 32'(occupancy1), 32'h1);
      drive1(0, 0, 0, 0, 8'h33);
      chk("d1_hold_data", 2, 32'(out_data1),  32'hFF);
      chk("d1_hold_occ",  2, 32'(occupancy1), 32'h1);
      drive1(0, 0, 1, 0, 8'h12);
      chk("d1_bub_data",  3, 32'(out_data1),  32'h12);
      chk("d1_bub_valid", 3, 32'(out_valid1), 32'h0);
      chk("d1_bub_occ",   3, 32'(occupancy1), 32'h0);
      drive1(0, 0, 1, 1, 8'h7E);
      drive1(0, 1, 1, 1, 8'h44);
      chk("d1_fl_data",  5, 32'(out_data1),  32'h00);
      chk("d1_fl_valid", 5, 32'(out_valid1), 32'h0);

      // Randomised traffic against the queue reference
      for (int i = 0; i < 400; i++) begin
         logic r, f, e, v;
         logic [7:0] d;
         r = ($urandom_range(0, 59) == 0);
         f = ($urandom_range(0, 24) == 0);
         e = ($urandom_range(0, 3) != 0);
         v = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         drive(r, f, e, v, d);
         chk("rnd_data",  i, 32'(out_data),  32'(sb[0].d));
         chk("rnd_valid", i, 32'(out_valid), 32'(sb[0].v));
         chk("rnd_occ",   i, 32'(occupancy), 32'(sb_occ()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
